// File: rtl/tempsens_pkg.sv
// rtl/tempsens_pkg.sv - shared encodings for the RO temperature sensor blocks
package tempsens_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      COUNT  = 2'd2
   } state_t;

   localparam logic [1:0] SEL_SUM_HI = 2'd0;
   localparam logic [1:0] SEL_SUM_LO = 2'd1;

   localparam logic [7:0] START_CODE = 8'hA5;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - 2-FF synchronizer with a one-cycle rising-edge pulse
module sync_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic sig,
   output logic pulse
);

   logic s1;
   logic s2;
   logic s3;

   // only s1 may go metastable; s3 is the history flop for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign pulse = s2 & ~s3;

endmodule

// File: rtl/ro_sum_accumulator.sv
// rtl/ro_sum_accumulator.sv - RO edge counter averaging NUM_WINDOWS gate windows into sum
module ro_sum_accumulator
   import tempsens_pkg::*;
#(
   parameter int WINDOW_CYCLES = 1000,
   parameter int NUM_WINDOWS   = 4,
   parameter int SETTLE_CYCLES = 16,
   parameter int SUM_W         = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sum_en,
   input  logic             ro_in,
   input  logic [1:0]       send_sel,
   output logic             sum_ready,
   output logic [SUM_W-1:0] sum,
   output logic [7:0]       tx_byte
);

   localparam int SHIFT = $clog2(NUM_WINDOWS);
   localparam int ACC_W = SUM_W + SHIFT + 1;
   localparam int WC_W  = $clog2(WINDOW_CYCLES);
   localparam int WI_W  = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;
   localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WINDOW_CYCLES - 1);
   localparam logic [WI_W-1:0]  WI_LAST = WI_W'(NUM_WINDOWS - 1);
   localparam logic [SC_W-1:0]  SC_LAST = SC_W'(SETTLE_CYCLES - 1);
   localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
   localparam logic [ACC_W-1:0] SUM_MAX = {{(ACC_W - SUM_W){1'b0}}, {SUM_W{1'b1}}};

   state_t           state;
   state_t           state_n;
   logic [SC_W-1:0]  settle_cnt;
   logic [SC_W-1:0]  settle_cnt_n;
   logic [WC_W-1:0]  win_cnt;
   logic [WC_W-1:0]  win_cnt_n;
   logic [WI_W-1:0]  win_idx;
   logic [WI_W-1:0]  win_idx_n;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_n;
   logic [ACC_W-1:0] acc_inc;
   logic [ACC_W-1:0] avg;
   logic [SUM_W-1:0] sum_n;
   logic             publish;
   logic             ro_edge;
   logic [15:0]      sum_ext;

   sync_edge_det u_sync (
      .clk   (clk),
      .reset (reset),
      .sig   (ro_in),
      .pulse (ro_edge)
   );

   // acc_inc already includes this cycle's edge, so the final window edge counts
   assign acc_inc = (acc == ACC_MAX) ? acc : acc + ACC_W'(ro_edge);
   assign avg     = acc_inc >> SHIFT;
   assign sum_n   = (avg > SUM_MAX) ? {SUM_W{1'b1}} : avg[SUM_W-1:0];

   always_comb begin
      state_n      = state;
      settle_cnt_n = settle_cnt;
      win_cnt_n    = win_cnt;
      win_idx_n    = win_idx;
      acc_n        = acc;
      publish      = 1'b0;

      case (state)
         IDLE: begin
            settle_cnt_n = '0;
            win_cnt_n    = '0;
            win_idx_n    = '0;
            acc_n        = '0;
            if (sum_en) state_n = SETTLE;
         end
         SETTLE: begin
            settle_cnt_n = settle_cnt + 1'b1;
            if (settle_cnt == SC_LAST) begin
               state_n      = COUNT;
               settle_cnt_n = '0;
               win_cnt_n    = '0;
               win_idx_n    = '0;
               acc_n        = '0;
            end
         end
         COUNT: begin
            acc_n     = acc_inc;
            win_cnt_n = win_cnt + 1'b1;
            if (win_cnt == WC_LAST) begin
               win_cnt_n = '0;
               win_idx_n = win_idx + 1'b1;
               if (win_idx == WI_LAST) begin
                  publish   = 1'b1;
                  win_idx_n = '0;
                  acc_n     = '0;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // losing enable discards the partial measurement, even on a window end
      if (state != IDLE && !sum_en) begin
         state_n      = IDLE;
         settle_cnt_n = '0;
         win_cnt_n    = '0;
         win_idx_n    = '0;
         acc_n        = '0;
         publish      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         settle_cnt <= '0;
         win_cnt    <= '0;
         win_idx    <= '0;
         acc        <= '0;
         sum        <= '0;
         sum_ready  <= 1'b0;
      end else begin
         state      <= state_n;
         settle_cnt <= settle_cnt_n;
         win_cnt    <= win_cnt_n;
         win_idx    <= win_idx_n;
         acc        <= acc_n;
         sum_ready  <= publish;
         if (publish) sum <= sum_n;
      end
   end

   assign sum_ext = 16'(sum);

   always_comb begin
      tx_byte = 8'h00;
      case (send_sel)
         SEL_SUM_HI: tx_byte = sum_ext[15:8];
         SEL_SUM_LO: tx_byte = sum_ext[7:0];
         default:    tx_byte = 8'h00;
      endcase
   end

endmodule

// File: doc/ro_sum_accumulator.md
Name: ro_sum_accumulator

Overview:
- Measurement front-end of the RO temperature sensor; sits directly upstream of the measurement/UART sequencing controller.
- Counts rising edges of the (pre-divided) ring-oscillator signal over NUM_WINDOWS gate windows of WINDOW_CYCLES clocks each, then publishes the average edge count per window as `sum`.
- Handshake with the controller:
  - Controller drives `sum_en` and `send_sel`.
  - This block returns `sum_ready` and the UART payload byte `tx_byte`.

Parameters:
- WINDOW_CYCLES, 1000: clock cycles per gate window (≥ 2).
- NUM_WINDOWS, 4: windows averaged per result; power of two, ≥ 1.
- SETTLE_CYCLES, 16: cycles discarded after `sum_en` rises (RO start-up); ≥ 1.
- SUM_W, 16: width of published `sum` (1..16).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- sum_en, input, 1: measurement enable from controller.
- ro_in, input, 1: asynchronous divided RO output; guaranteed frequency ≤ clk/4.
- send_sel, input, 2: byte select from controller.
- sum_ready, output, 1: one-cycle pulse when a new `sum` is published.
- sum, output, SUM_W: last published averaged count.
- tx_byte, output, 8: byte for UART TX, combinational from `send_sel` and `sum`.

Behaviour:
- Reset: all outputs clear.
  - `sum` = 0, `sum_ready` = 0.
  - Synchronizer flops = 0.
  - State = IDLE, all counters = 0.
  - Reset takes priority over every other event, including mid-window.
- Input path: `ro_in` goes through a 2-FF synchronizer, then a third flop. `edge = s2 & ~s3`, one cycle per rising edge.
- Accumulator `acc`: width SUM_W + log2(NUM_WINDOWS) + 1. Saturates at its maximum value and never wraps.
- States:
  - IDLE:
    - Counters and `acc` held at 0.
    - `sum_en` = 1 → SETTLE.
  - SETTLE:
    - Counts SETTLE_CYCLES cycles; edges are ignored.
    - On the last settle cycle → COUNT, with `win_cnt` = 0 and `win_idx` = 0.
  - COUNT:
    - Each cycle: `acc += edge`, `win_cnt++`.
    - At `win_cnt` == WINDOW_CYCLES-1: `win_cnt` = 0, `win_idx++`.
    - At the end of window NUM_WINDOWS-1 (that cycle's edge included):
      - `sum` ← min(`acc_final` >> log2(NUM_WINDOWS), 2^SUM_W − 1).
      - `sum_ready` = 1 on the next cycle, coincident with the new `sum`.
      - `acc` and counters clear.
      - Stay in COUNT (back-to-back measurement, no re-settle) if `sum_en` is still 1.
- `sum_en` = 0 in any non-IDLE state:
  - Next state is IDLE; partial `acc` and counters are discarded.
  - `sum` holds its value; no `sum_ready` pulse.
  - This takes priority over a window end on the same cycle.
- Latency: first `sum_ready` comes SETTLE_CYCLES + NUM_WINDOWS*WINDOW_CYCLES + 1 cycles after the first cycle `sum_en` is seen high.
- `sum` changes only on a `sum_ready` cycle or on reset. It is stable while the controller sends, because `sum_en` is low then.
- `tx_byte` (`sum` zero-extended to 16 bits = S):
  - `send_sel` 0 → S[15:8] (MSB first).
  - `send_sel` 1 → S[7:0].
  - `send_sel` 2 or 3 → 8'h00.
- `ro_in` held constant → `sum` = 0 after a full measurement.
- Metastability is confined to the first synchronizer flop. No `ro_in`-derived signal is used as a clock.

Decomposition:
- Shared package `tempsens_pkg`:
  - State encoding localparams (IDLE, SETTLE, COUNT).
  - Byte-select codes (SEL_SUM_HI = 0, SEL_SUM_LO = 1), also used by the controller.
  - START_CODE.
- One natural sub-module, `sync_edge_det`: 2-FF synchronizer plus rising-edge pulse. It is reusable for `rx` and other async inputs.
- Top module holds the FSM, counters, accumulator, saturation logic and byte mux.

Test Plan:
- Nominal average:
  - Stimulus: WINDOW_CYCLES = 100, NUM_WINDOWS = 4, SETTLE_CYCLES = 16; `ro_in` period 10 clk; `sum_en` held high.
  - Response: `sum_ready` pulses 417 cycles after `sum_en` rises, with `sum` = 10, then every 400 cycles with `sum` = 10.
- Byte mux:
  - Stimulus: after the nominal run, `sum` = 0x000A; sweep `send_sel` 0, 1, 2.
  - Response: `tx_byte` = 0x00, 0x0A, 0x00.
- Saturation:
  - Stimulus: SUM_W = 4, WINDOW_CYCLES = 100, NUM_WINDOWS = 1; `ro_in` period 4 clk (25 edges).
  - Response: `sum` = 15, `sum_ready` pulses once.
- Abort:
  - Stimulus: `sum` = 10 published; re-enable, then drop `sum_en` at cycle 250 of the measurement.
  - Response: no `sum_ready`, `sum` stays 10. On re-enable the next result arrives a full 417 cycles later and is 10.
- Reset mid-measurement:
  - Stimulus: assert `reset` for 1 cycle during COUNT.
  - Response: next cycle `sum` = 0, `sum_ready` = 0, state IDLE; no publish until `sum_en` is seen high again after reset.
- Static input:
  - Stimulus: `ro_in` stuck at 1; nominal parameters.
  - Response: `sum_ready` at cycle 417 with `sum` = 0.
